mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
Word-addressed instruction/data memory that sits opposite the multicycle control FSM on the memory interface. It accepts one read or write request, holds it for a fixed LATENCY cycles, then answers with a one-cycle ack pulse; the control FSM's wait states are sized to LATENCY. It replaces the ideal zero-wait memory model with an explicit handshake, range checking and alignment checking.

Parameters:
DATA_W, 32, data word width in bits
ADDR_W, 8, word-index width; memory depth is 2**ADDR_W words
LATENCY, 3, cycles from request acceptance to ack; legal range 1..15

Ports:
clk  input  1  system clock
rst  input  1  reset; synchronous and active-high
req  input  1  request strobe; sampled only when the block is accepting
we  input  1  1 = write, 0 = read; qualified by req
addr  input  32  byte address; word index = addr[ADDR_W+1:2]
wdata  input  DATA_W  write data; qualified by req and we
rdata  output  DATA_W  read data; valid while ack=1 for a read, held until the next read ack
ack  output  1  one-cycle completion pulse
err  output  1  high with ack when the request was misaligned or out of range
busy  output  1  high while a request is pending and no ack has been given yet

Behaviour:
- All state changes on posedge clk. rst takes priority over every other input.
- Reset values: ack=0, err=0, busy=0, rdata=0, state=IDLE, latch registers=0. Memory contents are not cleared.
- States:
  - IDLE: accepting.
  - WAIT: counting down.
  - RESP: the ack cycle; also accepting.
- Accept rule: in IDLE or RESP with req=1, latch we, addr and wdata.
  - LATENCY=1 -> next state is RESP.
  - Otherwise -> next state is WAIT with cnt=LATENCY-1.
- Ignore rule: req in WAIT is ignored, not queued. Latched values are not changed.
- WAIT: cnt decrements each cycle. When cnt==1, the next state is RESP.
- RESP with no req: the next state is IDLE.
- Timing for req sampled high in cycle n:
  - ack=1 in cycle n+LATENCY only.
  - busy=1 in cycles n+1..n+LATENCY-1 and 0 in the ack cycle.
  - Throughput is one request per LATENCY cycles.
- Error condition: addr[1:0]!=0, or addr[31:ADDR_W+2]!=0.
  - The latched error flag is evaluated at acceptance.
  - err=1 in the ack cycle.
  - No memory write occurs.
  - rdata is driven 0 for an errored read.
- Write commit:
  - The word is written on the clock edge that enters RESP.
  - rdata is unchanged by a write.
  - A read accepted during the write's ack cycle returns the new value.
- Read: rdata is loaded on the edge entering RESP with mem[index] and holds afterward.
- Reset mid-operation (in WAIT): the pending request is discarded, no write occurs, and no ack is ever produced for it.
- Simultaneous req and rst: rst wins and the request is dropped.
- LATENCY outside 1..15 is illegal. An elaboration-time check must flag it.

Test Plan:
- Reset, then read at addr 0x0 (LATENCY=3) -> ack=1 exactly 3 cycles after req; busy=1 for the 2 intervening cycles; err=0.
- Write 0xDEADBEEF to 0x10, then read 0x10 issued in the write's ack cycle -> second ack 3 cycles later with rdata=0xDEADBEEF.
- Read at 0x13 (misaligned) and at 0x400 (out of range with ADDR_W=8) -> ack with err=1 and rdata=0. Follow-up read of 0x10 still returns the old value, proving no write occurred.
- Hold req=1 with alternating addresses 0x4 and 0x8 for 12 cycles -> exactly 4 acks, spaced 3 cycles apart; requests during WAIT are ignored.
- Write to 0x20 with rst asserted one cycle after acceptance -> no ack. A read of 0x20 afterward returns the pre-write contents.
- LATENCY=1 build: back-to-back reads on consecutive cycles -> ack every cycle, busy never asserted, rdata tracks each address one cycle later.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder: word-addressed memory with a fixed-latency request/ack
// handshake. It is meant to face a multicycle control FSM whose wait states
// match LATENCY.
//
// Handshake: req is sampled only when the block is accepting, meaning in
// IDLE or in the ack cycle (RESP). A request seen there is latched, and
// exactly LATENCY cycles later ack pulses for one cycle. busy stays high
// over the cycles in between. A req seen while busy is dropped, not queued.
//
// Ports:
//   clk       system clock
//   rst       synchronous, active-high reset
//   req       request strobe
//   we        1 = write, 0 = read (qualified by req)
//   addr      byte address; the word index is addr[ADDR_W+1:2]
//   wdata     write data
//   rdata     read data; valid with ack on a read and held until the next read ack
//   ack       one-cycle completion pulse
//   err       high with ack when the address was misaligned or out of range
//   busy      a request is pending and has not been acked yet
//   dbg_state current FSM state (debug observation)
module mem_responder #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [31:0]       addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ack,
  output logic              err,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  generate
    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
      $error("mem_responder: LATENCY must be within 1..15");
    end
    if (ADDR_W < 1 || ADDR_W > 29) begin : g_bad_addr_w
      $error("mem_responder: ADDR_W must be within 1..29");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t              r_state;
  logic [3:0]          r_cnt;
  logic                r_we;
  logic                r_err;
  logic [ADDR_W-1:0]   r_idx;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_ack;
  logic                r_err_o;
  logic                r_busy;
  logic [DATA_W-1:0]   r_rdata;
  logic [DATA_W-1:0]   r_mem [2**ADDR_W];

  logic                w_accept;
  logic                w_addr_err;
  logic                w_enter_resp;
  logic                w_rsp_we;
  logic                w_rsp_err;
  logic [ADDR_W-1:0]   w_rsp_idx;
  logic [DATA_W-1:0]   w_rsp_wdata;

  assign w_accept   = (r_state != WAIT) && req;
  assign w_addr_err = (addr[1:0] != 2'b00) || (addr[31:ADDR_W+2] != '0);

  // With LATENCY=1 the accepting edge is also the edge entering RESP, so the
  // request is served straight from the ports instead of the latches.
  assign w_enter_resp = (LATENCY == 1) ? w_accept
                                       : ((r_state == WAIT) && (r_cnt == 4'd1));
  assign w_rsp_we     = (LATENCY == 1) ? we                   : r_we;
  assign w_rsp_err    = (LATENCY == 1) ? w_addr_err           : r_err;
  assign w_rsp_idx    = (LATENCY == 1) ? addr[ADDR_W+1:2]     : r_idx;
  assign w_rsp_wdata  = (LATENCY == 1) ? wdata                : r_wdata;

  // The write commits on the edge entering RESP, so a read accepted in the
  // ack cycle already sees the new word. Reset drops a pending write.
  always_ff @(posedge clk) begin
    if (!rst && w_enter_resp && w_rsp_we && !w_rsp_err) begin
      r_mem[w_rsp_idx] <= w_rsp_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_idx   <= '0;
      r_wdata <= '0;
      r_ack   <= 1'b0;
      r_err_o <= 1'b0;
      r_busy  <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ack   <= w_enter_resp;
      r_err_o <= w_enter_resp && w_rsp_err;
      if (w_enter_resp && !w_rsp_we) begin
        r_rdata <= w_rsp_err ? '0 : r_mem[w_rsp_idx];
      end
      if (w_accept) begin
        r_we    <= we;
        r_err   <= w_addr_err;
        r_idx   <= addr[ADDR_W+1:2];
        r_wdata <= wdata;
      end
      case (r_state)
        IDLE, RESP: begin
          if (w_accept) begin
            if (LATENCY == 1) begin
              r_state <= RESP;
              r_busy  <= 1'b0;
            end else begin
              r_state <= WAIT;
              r_cnt   <= CNT_INIT;
              r_busy  <= 1'b1;
            end
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        WAIT: begin
          if (r_cnt == 4'd1) begin
            r_state <= RESP;
            r_busy  <= 1'b0;
          end else begin
            r_cnt  <= r_cnt - 4'd1;
            r_busy <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign rdata     = r_rdata;
  assign ack       = r_ack;
  assign err       = r_err_o;
  assign busy      = r_busy;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder. Two instances, one with LATENCY=3 and one with
// LATENCY=1, are driven by the same inputs. A cycle-level reference model
// checks both on every cycle. Hand-written expectations cover the main
// scenarios.
module tb_mem_responder;
  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;

  logic [31:0] rdata3, rdata1;
  logic        ack3, err3, busy3, ack1, err1, busy1;
  logic [1:0]  st3, st1;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_responder #(.DATA_W(32), .ADDR_W(8), .LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata3), .ack(ack3), .err(err3), .busy(busy3), .dbg_state(st3));

  mem_responder #(.DATA_W(32), .ADDR_W(8), .LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata1), .ack(ack1), .err(err1), .busy(busy1), .dbg_state(st1));

  // ---------------- reference model (index 0: LATENCY=3, 1: LATENCY=1)
  int          lat [2] = '{3, 1};
  logic [31:0] m_mem [2][DEPTH];
  bit          m_pend [2];
  int          m_due [2];
  bit          m_we [2];
  bit          m_er [2];
  int          m_idx [2];
  logic [31:0] m_wd [2];
  bit          e_ack [2];
  bit          e_err [2];
  logic [31:0] e_rd [2];
  int          t = 0;

  function automatic bit addr_bad(input logic [31:0] a);
    return (a % 4 != 0) || (a >= 4 * DEPTH);
  endfunction

  task automatic complete(input int k);
    e_ack[k] = 1'b1;
    e_err[k] = m_er[k];
    if (m_we[k] && !m_er[k]) m_mem[k][m_idx[k]] = m_wd[k];
    if (!m_we[k]) e_rd[k] = m_er[k] ? 32'd0 : m_mem[k][m_idx[k]];
    m_pend[k] = 1'b0;
  endtask

  // One clock edge: requests are accepted when nothing is pending, and the
  // response lands LATENCY cycles after the accepting cycle.
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_pend[k] = 1'b0;
        e_ack[k]  = 1'b0;
        e_err[k]  = 1'b0;
        e_rd[k]   = 32'd0;
      end else begin
        e_ack[k] = 1'b0;
        e_err[k] = 1'b0;
        if (!m_pend[k] && req) begin
          m_pend[k] = 1'b1;
          m_due[k]  = t + lat[k];
          m_we[k]   = we;
          m_er[k]   = addr_bad(addr);
          m_idx[k]  = int'(addr >> 2) % DEPTH;
          m_wd[k]   = wdata;
        end
      end
    end
    t++;
    for (int k = 0; k < 2; k++) begin
      if (!rst && m_pend[k] && t == m_due[k]) complete(k);
    end
  endtask

  // ---------------- checking
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, t);
    end
  endtask

  task automatic check_all();
    chk("l3_ack_err_busy", {29'd0, ack3, err3, busy3}, {29'd0, e_ack[0], e_err[0], m_pend[0]});
    chk("l3_rdata", rdata3, e_rd[0]);
    chk("l1_ack_err_busy", {29'd0, ack1, err1, busy1}, {29'd0, e_ack[1], e_err[1], m_pend[1]});
    chk("l1_rdata", rdata1, e_rd[1]);
  endtask

  // ---------------- drivers
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  // Issue one request and wait (bounded) for the LATENCY=3 ack.
  task automatic xact(input bit w, input logic [31:0] a, input logic [31:0] d,
                      output int lat_seen, output int busy_cnt,
                      output bit err_seen, output logic [31:0] rd_seen);
    req = 1'b1; we = w; addr = a; wdata = d;
    tick();
    req = 1'b0;
    lat_seen = 0; busy_cnt = 0; err_seen = 1'b0; rd_seen = '0;
    for (int i = 1; i <= 20; i++) begin
      if (ack3) begin
        lat_seen = i; err_seen = err3; rd_seen = rdata3;
        break;
      end
      if (busy3) busy_cnt++;
      tick();
    end
  endtask

  typedef struct {
    bit          w;
    logic [31:0] a;
    logic [31:0] d;
    bit          exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  initial begin
    vec_t        vecs [13];
    int          lat_seen, busy_cnt, n_ack;
    bit          err_seen;
    logic [31:0] rd_seen;
    int          ack_at [$];

    vecs[0]  = '{1'b1, 32'h10,  32'hDEADBEEF, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 32'h10,  32'h0,        1'b0, 32'hDEADBEEF};
    vecs[2]  = '{1'b0, 32'h13,  32'h0,        1'b1, 32'h0};
    vecs[3]  = '{1'b0, 32'h400, 32'h0,        1'b1, 32'h0};
    vecs[4]  = '{1'b0, 32'h10,  32'h0,        1'b0, 32'hDEADBEEF};
    vecs[5]  = '{1'b1, 32'h11,  32'h12345678, 1'b1, 32'hDEADBEEF};
    vecs[6]  = '{1'b0, 32'h10,  32'h0,        1'b0, 32'hDEADBEEF};
    vecs[7]  = '{1'b0, 32'h3FC, 32'h0,        1'b0, 32'h100000FF};
    vecs[8]  = '{1'b1, 32'h3FC, 32'hCAFEF00D, 1'b0, 32'h100000FF};
    vecs[9]  = '{1'b0, 32'h3FC, 32'h0,        1'b0, 32'hCAFEF00D};
    vecs[10] = '{1'b1, 32'h404, 32'h55555555, 1'b1, 32'hCAFEF00D};
    vecs[11] = '{1'b0, 32'h0,   32'h0,        1'b0, 32'h10000000};
    vecs[12] = '{1'b0, 32'hFFFFFFFC, 32'h0,   1'b1, 32'h0};

    for (int k = 0; k < 2; k++) begin
      m_pend[k] = 1'b0; e_ack[k] = 1'b0; e_err[k] = 1'b0; e_rd[k] = '0;
      for (int i = 0; i < DEPTH; i++) m_mem[k][i] = '0;
    end

    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_ack3", {31'd0, ack3}, 32'd0);
    chk("rst_busy3", {31'd0, busy3}, 32'd0);
    chk("rst_err3", {31'd0, err3}, 32'd0);
    chk("rst_rdata3", rdata3, 32'd0);
    chk("rst_rdata1", rdata1, 32'd0);
    rst = 1'b0;

    // Fill memory with a known pattern
    for (int i = 0; i < DEPTH; i++) begin
      xact(1'b1, 32'(i) << 2, 32'h10000000 | 32'(i), lat_seen, busy_cnt, err_seen, rd_seen);
    end

    // Table of single transactions
    for (int v = 0; v < 13; v++) begin
      xact(vecs[v].w, vecs[v].a, vecs[v].d, lat_seen, busy_cnt, err_seen, rd_seen);
      chk($sformatf("vec%0d_latency", v), 32'(lat_seen), 32'd3);
      chk($sformatf("vec%0d_busy_cycles", v), 32'(busy_cnt), 32'd2);
      chk($sformatf("vec%0d_err", v), {31'd0, err_seen}, {31'd0, vecs[v].exp_err});
      chk($sformatf("vec%0d_rdata", v), rd_seen, vecs[v].exp_rd);
    end

    // Reset while a write waits: no ack, no write
    req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'hAAAA5555;
    tick();
    req = 1'b0; rst = 1'b1;
    tick();
    chk("rstmid_busy", {31'd0, busy3}, 32'd0);
    rst = 1'b0;
    n_ack = 0;
    repeat (4) begin
      tick();
      if (ack3) n_ack++;
    end
    chk("rstmid_no_ack", 32'(n_ack), 32'd0);
    xact(1'b0, 32'h20, 32'h0, lat_seen, busy_cnt, err_seen, rd_seen);
    chk("rstmid_read_lat", 32'(lat_seen), 32'd3);
    chk("rstmid_read_old", rd_seen, 32'h10000008);

    // Read issued in the write's ack cycle sees the new word
    xact(1'b1, 32'h28, 32'h11112222, lat_seen, busy_cnt, err_seen, rd_seen);
    xact(1'b0, 32'h28, 32'h0, lat_seen, busy_cnt, err_seen, rd_seen);
    chk("raw_lat", 32'(lat_seen), 32'd3);
    chk("raw_rdata", rd_seen, 32'h11112222);

    // req held for 12 cycles: one request per 3 cycles
    for (int i = 1; i <= 12; i++) begin
      req = 1'b1; we = 1'b0; addr = (i % 2 == 1) ? 32'h4 : 32'h8;
      tick();
      if (ack3) ack_at.push_back(i);
    end
    req = 1'b0;
    chk("hold_ack_count", 32'(ack_at.size()), 32'd4);
    for (int j = 0; j < ack_at.size(); j++) begin
      chk($sformatf("hold_ack%0d_pos", j), 32'(ack_at[j]), 32'(3 * (j + 1)));
    end
    repeat (3) tick();

    // req together with rst is dropped
    req = 1'b1; we = 1'b1; addr = 32'h30; wdata = 32'h77777777; rst = 1'b1;
    tick();
    req = 1'b0; rst = 1'b0;
    n_ack = 0;
    repeat (4) begin
      tick();
      if (ack3 || ack1) n_ack++;
    end
    chk("rstreq_no_ack", 32'(n_ack), 32'd0);
    xact(1'b0, 32'h30, 32'h0, lat_seen, busy_cnt, err_seen, rd_seen);
    chk("rstreq_read_old", rd_seen, 32'h1000000C);

    // LATENCY=1: back-to-back reads, ack every cycle, never busy
    for (int i = 0; i < 8; i++) begin
      req = 1'b1; we = 1'b0; addr = 32'(i) << 2;
      tick();
      chk($sformatf("l1_b2b%0d_ack", i), {30'd0, ack1, busy1}, 32'd2);
      chk($sformatf("l1_b2b%0d_rdata", i), rdata1,
          (i == 4) ? 32'hDEADBEEF : (32'h10000000 | 32'(i)));
    end
    req = 1'b0;
    repeat (4) tick();

    // Random traffic against the model
    for (int n = 0; n < 1500; n++) begin
      int idx, sel;
      rst   = ($urandom_range(0, 99) < 2);
      req   = ($urandom_range(0, 1) == 1);
      we    = ($urandom_range(0, 3) == 0);
      wdata = $urandom;
      idx   = $urandom_range(0, 31);
      sel   = $urandom_range(0, 9);
      if (sel == 0)      addr = (32'(idx) << 2) | 32'($urandom_range(1, 3));
      else if (sel == 1) addr = (32'($urandom_range(1, 4000)) << 10) | (32'(idx) << 2);
      else               addr = 32'(idx) << 2;
      tick();
    end
    rst = 1'b0; req = 1'b0;
    repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
